// File: rtl/tiny_cpu_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : tiny_cpu_host_tx
// Purpose  : Outbound byte port. The CPU pushes bytes into a small FIFO and
//            each byte is driven on the uio pins with a four-phase req/ack
//            handshake against an external host whose ack is asynchronous.
// Revision : 1.0 - initial release
// ============================================================================
module tiny_cpu_host_tx #(
  parameter int DEPTH     = 4,
  parameter int SETUP_CYC = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [7:0]                 wr_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       ovf,
  input  logic                       clr_ovf,
  input  logic                       host_ack_i,
  output logic [7:0]                 bus_data_o,
  output logic [7:0]                 bus_oe_o,
  output logic                       bus_req_o,
  output logic                       busy
);

  localparam int                 c_addr_w = $clog2(DEPTH);
  localparam int                 c_lvl_w  = c_addr_w + 1;
  localparam logic [c_lvl_w-1:0] c_depth  = c_lvl_w'(DEPTH);
  localparam logic [3:0]         c_setup  = 4'(SETUP_CYC);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETUP   = 2'd1,
    S_REQ     = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  logic [7:0]          r_mem [DEPTH];
  logic [c_addr_w-1:0] r_wr_ptr;
  logic [c_addr_w-1:0] r_rd_ptr;
  logic [c_lvl_w-1:0]  r_count;
  logic [c_lvl_w-1:0]  w_count_nxt;
  logic                r_full;
  logic                r_empty;
  logic                r_ovf;
  logic                w_wr;
  logic                w_pop;

  logic                r_ack_meta;
  logic                r_ack_s;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_setup_cnt;
  logic [3:0]          w_setup_cnt_nxt;

  logic [7:0]          r_bus_data;
  logic [7:0]          r_bus_oe;
  logic                r_bus_req;
  logic                r_busy;

  // Writes are gated by the registered (pre-edge) full flag.
  assign w_wr = wr_en & ~r_full;

  // Occupancy after this edge; a simultaneous write and pop cancel out.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage array; no reset needed since occupancy tracking guards reads.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // FIFO pointers, occupancy and registered full/empty flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_depth);
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Sticky overflow; a new overflow beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (wr_en && r_full) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  // Two-flop synchronizer for the asynchronous host ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack_meta <= 1'b0;
      r_ack_s    <= 1'b0;
    end else begin
      r_ack_meta <= host_ack_i;
      r_ack_s    <= r_ack_meta;
    end
  end

  // Handshake next-state logic; pops only when launching a new byte.
  always_comb begin
    w_state_nxt     = r_state;
    w_setup_cnt_nxt = r_setup_cnt;
    w_pop           = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_empty && !r_ack_s) begin
          w_pop           = 1'b1;
          w_setup_cnt_nxt = c_setup;
          w_state_nxt     = S_SETUP;
        end
      end
      S_SETUP: begin
        if (r_setup_cnt <= 4'd1) begin
          w_state_nxt = S_REQ;
        end else begin
          w_setup_cnt_nxt = r_setup_cnt - 4'd1;
        end
      end
      S_REQ: begin
        if (r_ack_s) begin
          w_state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!r_ack_s) begin
          if (!r_empty) begin
            w_pop           = 1'b1;
            w_setup_cnt_nxt = c_setup;
            w_state_nxt     = S_SETUP;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, setup counter and registered bus outputs derived from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_setup_cnt <= 4'd0;
      r_bus_data  <= 8'h00;
      r_bus_oe    <= 8'h00;
      r_bus_req   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_setup_cnt <= w_setup_cnt_nxt;
      if (w_pop) begin
        r_bus_data <= r_mem[r_rd_ptr];
      end
      r_bus_oe  <= (w_state_nxt != S_IDLE) ? 8'hFF : 8'h00;
      r_bus_req <= (w_state_nxt == S_REQ);
      r_busy    <= (w_state_nxt != S_IDLE);
    end
  end

  assign full       = r_full;
  assign empty      = r_empty;
  assign level      = r_count;
  assign ovf        = r_ovf;
  assign bus_data_o = r_bus_data;
  assign bus_oe_o   = r_bus_oe;
  assign bus_req_o  = r_bus_req;
  assign busy       = r_busy;

endmodule
`default_nettype wire
